// File: rtl/mem_port_arbiter.sv
// Arbitrates the single word-wide memory port between I-cache fills and D-cache fills/write-backs,
// sequencing each line as LINE_WORDS beats of MEM_LATENCY cycles and generating the pipeline stall vector.
module mem_port_arbiter #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        cacheStall,
  output logic [1:0]        dbg_state
);

  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, I_XFER = 2'd1, D_XFER = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              d_wnext_q, d_wnext_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

  logic grant_i, grant_d;
  logic xfer_d, beat_end_d;
  logic stall_d_side, stall_i_side;

  // DONE only ever hands the port to the other side, which is what forces I/D alternation.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    we_d    = we_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req)      grant_d = 1'b1;
        else if (i_req) grant_i = 1'b1;
      end
      I_XFER, D_XFER: begin
        if (lat_q == LAT_LAST) begin
          lat_d = '0;
          if (beat_q == BEAT_LAST) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE: begin
        if (owner_q == OWN_D && i_req)      grant_i = 1'b1;
        else if (owner_q == OWN_I && d_req) grant_d = 1'b1;
        else                                state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_d) begin
      state_d = D_XFER;
      owner_d = OWN_D;
      base_d  = d_addr & ~LINE_MASK;
      we_d    = d_we;
      beat_d  = '0;
      lat_d   = '0;
    end
    if (grant_i) begin
      state_d = I_XFER;
      owner_d = OWN_I;
      base_d  = i_addr & ~LINE_MASK;
      we_d    = 1'b0;
      beat_d  = '0;
      lat_d   = '0;
    end

    // Port outputs are decoded from the next state so they come straight off flops.
    xfer_d     = (state_d == I_XFER) || (state_d == D_XFER);
    beat_end_d = xfer_d && (lat_d == LAT_LAST);
    m_read_d   = xfer_d && !we_d;
    m_write_d  = xfer_d && we_d;
    m_addr_d   = xfer_d ? (base_d | ADDR_W'(beat_d)) : '0;
    i_rvalid_d = (state_d == I_XFER) && beat_end_d;
    d_rvalid_d = (state_d == D_XFER) && beat_end_d && !we_d;
    d_wnext_d  = (state_d == D_XFER) && beat_end_d && we_d;
    i_done_d   = (state_d == DONE) && (owner_d == OWN_I);
    d_done_d   = (state_d == DONE) && (owner_d == OWN_D);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      base_q     <= '0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      lat_q      <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_wnext_q  <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      base_q     <= base_d;
      we_q       <= we_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      d_wnext_q  <= d_wnext_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign m_read    = m_read_q;
  assign m_write   = m_write_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_write_q ? d_wdata : '0;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rvalid_q ? m_rdata : '0;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rvalid_q ? m_rdata : '0;
  assign d_wnext   = d_wnext_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign dbg_state = state_q;

  // Stall is held low while Reset is asserted so the pipe sees a clean all-zero vector.
  assign stall_d_side = d_req & ~d_done_q & ~Reset;
  assign stall_i_side = i_req & ~i_done_q & ~stall_d_side & ~Reset;
  assign cacheStall   = {stall_d_side, stall_i_side};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timing checks per transfer plus a scoreboard of expected read/write beats.
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int ML = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done, m_read, m_write;
  logic [1:0]  cacheStall, dbg_state;

  logic        i_req_2;
  logic [15:0] i_addr_2, i_rdata_2, d_rdata_2, m_addr_2, m_wdata_2, m_rdata_2;
  logic        i_rvalid_2, i_done_2, d_wnext_2, d_rvalid_2, d_done_2, m_read_2, m_write_2;
  logic [1:0]  cacheStall_2, dbg_state_2;

  logic [15:0] i_exp_q[$];
  logic [15:0] d_exp_q[$];
  logic [31:0] w_exp_q[$];
  logic [15:0] i2_exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign m_rdata   = 16'h1000 + m_addr;
  assign m_rdata_2 = 16'h1000 + m_addr_2;

  mem_port_arbiter #(.LINE_WORDS(LW), .MEM_LATENCY(ML), .ADDR_W(16), .DATA_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .cacheStall(cacheStall), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.LINE_WORDS(2), .MEM_LATENCY(1), .ADDR_W(16), .DATA_W(16)) u_dut2 (
    .Clk(Clk), .Reset(Reset),
    .i_req(i_req_2), .i_addr(i_addr_2), .i_rdata(i_rdata_2), .i_rvalid(i_rvalid_2), .i_done(i_done_2),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_wnext(d_wnext_2),
    .d_rdata(d_rdata_2), .d_rvalid(d_rvalid_2), .d_done(d_done_2),
    .m_addr(m_addr_2), .m_read(m_read_2), .m_write(m_write_2), .m_wdata(m_wdata_2), .m_rdata(m_rdata_2),
    .cacheStall(cacheStall_2), .dbg_state(dbg_state_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  // Scoreboard: every data beat the DUT delivers must match the head of the expected queue.
  always @(negedge Clk) begin
    if (i_rvalid) begin
      if (i_exp_q.size() == 0) check("i_rvalid_unexp", i_rvalid, 1'b0);
      else                     check("i_rdata", i_rdata, i_exp_q.pop_front());
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) check("d_rvalid_unexp", d_rvalid, 1'b0);
      else                     check("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (d_wnext) begin
      if (w_exp_q.size() == 0) check("d_wnext_unexp", d_wnext, 1'b0);
      else                     check("wb_addr_data", {m_addr, m_wdata}, w_exp_q.pop_front());
    end
  end

  task automatic push_line(input bit is_d, input logic [15:0] base);
    for (int k = 0; k < LW; k++) begin
      if (is_d) d_exp_q.push_back(16'h1000 + base + 16'(k));
      else      i_exp_q.push_back(16'h1000 + base + 16'(k));
    end
  endtask

  // Called at the sample point of the first strobe cycle; returns at the sample point of the done cycle.
  task automatic expect_xfer(input string tag, input bit is_d, input bit we,
                             input logic [15:0] base, input logic [1:0] stall);
    for (int k = 0; k < LW * ML; k++) begin
      bit last;
      last = ((k % ML) == ML - 1);
      check({tag, "_m_read"},   m_read, !we);
      check({tag, "_m_write"},  m_write, we);
      check({tag, "_m_addr"},   m_addr, base + 16'(k / ML));
      check({tag, "_i_rvalid"}, i_rvalid, !is_d && last);
      check({tag, "_d_rvalid"}, d_rvalid, is_d && !we && last);
      check({tag, "_d_wnext"},  d_wnext, is_d && we && last);
      check({tag, "_stall"},    cacheStall, stall);
      next_cycle();
      if (is_d && we && last) d_wdata = d_wdata + 16'h1;
      sample();
    end
    check({tag, "_done_rd"}, {m_read, m_write}, 2'b00);
    check({tag, "_i_done"},  i_done, !is_d);
    check({tag, "_d_done"},  d_done, is_d);
    check({tag, "_done_st"}, dbg_state, 2'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; i_req_2 = 1'b0; i_addr_2 = '0;

    // Reset state
    next_cycle(); next_cycle(); sample();
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_addr", m_addr, 16'h0);
    check("rst_pulses", {i_rvalid, i_done, d_rvalid, d_wnext, d_done}, 5'b0);
    check("rst_stall", cacheStall, 2'b00);
    check("rst_state", dbg_state, 2'd0);
    next_cycle(); Reset = 1'b0;

    // 1: I fill alone, unaligned address
    next_cycle(); i_req = 1'b1; i_addr = 16'h0047; push_line(1'b0, 16'h0044);
    sample(); check("t1_c0_stall", cacheStall, 2'b01);
    next_cycle(); sample(); expect_xfer("t1", 1'b0, 1'b0, 16'h0044, 2'b01);
    check("t1_done_stall", cacheStall, 2'b00);
    next_cycle(); i_req = 1'b0; sample();
    check("t1_idle", dbg_state, 2'd0);

    // 2: simultaneous requests, D wins, I follows with no idle cycle
    next_cycle(); i_req = 1'b1; i_addr = 16'h0047; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    push_line(1'b1, 16'h0100); push_line(1'b0, 16'h0044);
    sample(); check("t2_c0_stall", cacheStall, 2'b10);
    next_cycle(); sample(); expect_xfer("t2d", 1'b1, 1'b0, 16'h0100, 2'b10);
    check("t2_dd_stall", cacheStall, 2'b01);
    next_cycle(); d_req = 1'b0; sample(); expect_xfer("t2i", 1'b0, 1'b0, 16'h0044, 2'b01);
    check("t2_id_stall", cacheStall, 2'b00);
    next_cycle(); i_req = 1'b0;

    // 3: D write-back, data advanced on d_wnext
    next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0202; d_wdata = 16'h00A1;
    for (int k = 0; k < LW; k++) w_exp_q.push_back({16'h0200 + 16'(k), 16'h00A1 + 16'(k)});
    sample(); check("t3_c0_stall", cacheStall, 2'b10);
    next_cycle(); sample(); expect_xfer("t3", 1'b1, 1'b1, 16'h0200, 2'b10);
    next_cycle(); d_req = 1'b0; d_we = 1'b0;

    // 4: D then pending I; D re-requests right after d_done but I goes first
    next_cycle(); d_req = 1'b1; d_addr = 16'h0300; i_req = 1'b1; i_addr = 16'h0081;
    push_line(1'b1, 16'h0300); push_line(1'b0, 16'h0080);
    sample(); next_cycle(); sample(); expect_xfer("t4d", 1'b1, 1'b0, 16'h0300, 2'b10);
    next_cycle(); d_req = 1'b1; d_addr = 16'h0312; push_line(1'b1, 16'h0310);
    sample(); expect_xfer("t4i", 1'b0, 1'b0, 16'h0080, 2'b10);
    next_cycle(); i_req = 1'b0; sample(); expect_xfer("t4d2", 1'b1, 1'b0, 16'h0310, 2'b10);
    check("t4_end_stall", cacheStall, 2'b00);
    next_cycle(); d_req = 1'b0;

    // 5: reset in the middle of an I fill, held request restarts at beat 0
    next_cycle(); i_req = 1'b1; i_addr = 16'h0052;
    i_exp_q.push_back(16'h1050); i_exp_q.push_back(16'h1051);
    sample();
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); sample(); check("t5_pre_read", m_read, 1'b1);
    end
    next_cycle(); Reset = 1'b1; sample();
    check("t5_rst_stall", cacheStall, 2'b00);
    next_cycle(); Reset = 1'b0; sample();
    check("t5_strobes", {m_read, m_write}, 2'b00);
    check("t5_m_addr", m_addr, 16'h0);
    check("t5_pulses", {i_rvalid, i_done, d_rvalid, d_wnext, d_done}, 5'b0);
    check("t5_state", dbg_state, 2'd0);
    push_line(1'b0, 16'h0050);
    next_cycle(); sample(); expect_xfer("t5", 1'b0, 1'b0, 16'h0050, 2'b01);
    next_cycle(); i_req = 1'b0;

    // 6: MEM_LATENCY=1, LINE_WORDS=2 instance
    next_cycle(); i_req_2 = 1'b1; i_addr_2 = 16'h0011;
    i2_exp_q.push_back(16'h1010); i2_exp_q.push_back(16'h1011);
    sample();
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); sample();
      check("t6_m_read", m_read_2, 1'b1);
      check("t6_m_addr", m_addr_2, 16'h0010 + 16'(c - 1));
      check("t6_i_rvalid", i_rvalid_2, 1'b1);
      if (i2_exp_q.size() != 0) check("t6_i_rdata", i_rdata_2, i2_exp_q.pop_front());
    end
    next_cycle(); sample();
    check("t6_i_done", i_done_2, 1'b1);
    check("t6_m_read_off", m_read_2, 1'b0);
    next_cycle(); i_req_2 = 1'b0;

    next_cycle(); sample();
    check("q_i_empty", i_exp_q.size(), 0);
    check("q_d_empty", d_exp_q.size(), 0);
    check("q_w_empty", w_exp_q.size(), 0);
    check("q_i2_empty", i2_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
